id_ex_hazard_stage: RTL and testbench
=====================================

Name: id_ex_hazard_stage

Overview:
- Contains the ID/EX pipeline register of the 16-bit 5-stage core.
- Detects load-to-use hazards between the instruction in EX and the instruction in ID.
- Inserts bubbles on stall and squashes on branch flush.
- Its registered Rs/Rt/Rd and control fields feed the EX-stage forwarding unit and ALU. A saturating bubble counter is included for performance debug.

Parameters:
DATA_W, 16, datapath width
REG_W, 4, register specifier width (16 architectural regs, R0 hard-wired zero)
ALUOP_W, 4, ALU opcode field width
CNT_W, 16, width of bubble performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_W  ID source register 1
id_rt  in  REG_W  ID source register 2
id_rd  in  REG_W  ID destination register
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_regwrite  in  1  control: writes register file
id_memread  in  1  control: load
id_memwrite  in  1  control: store (rt = store data)
id_memtoreg  in  1  control: WB selects memory data
id_alusrc  in  1  control: ALU B selects immediate
id_aluop  in  ALUOP_W  ALU operation
id_halt  in  1  HLT instruction
id_rs_data  in  DATA_W  register file read data 1
id_rt_data  in  DATA_W  register file read data 2
id_imm  in  DATA_W  sign-extended immediate
id_pc_next  in  DATA_W  PC+2 of the ID instruction
flush  in  1  branch taken in EX: squash ID instruction
ex_hold  in  1  downstream (MEM) stall: freeze ID/EX
ex_valid, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_aluop, ex_halt, ex_rs_data, ex_rt_data, ex_imm, ex_pc_next  out  (matching widths)  registered ID/EX copies
load_use_stall  out  1  combinational: hold PC and IF/ID this cycle
bubble_count  out  CNT_W  saturating count of inserted load-use bubbles

Behaviour:
- Reset (rst_n=0, async): all ex_* outputs are 0, ex_valid=0, bubble_count=0. load_use_stall is 0 while in reset.
- Hazard term: haz = ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd & !id_memwrite)).
  - A store whose rt (data) matches the load rd does not stall; MEM-to-MEM forwarding covers it.
  - A store whose rs (address) matches the load rd does stall.
- load_use_stall = haz & !flush & !ex_hold.
- Per-cycle update priority, highest first:
  1. ex_hold=1: every ex_* register retains its value. flush is ignored; the upstream holds flush asserted until ex_hold drops.
  2. flush=1: bubble. ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_halt are 0. Data and specifier fields are don't-care, but implemented as 0.
  3. haz=1: same bubble as flush. bubble_count increments by 1 and saturates at all-ones (no wrap).
  4. Otherwise: load all id_* into ex_*. ex_valid=id_valid.
- When id_valid=0, control bits are loaded as 0 regardless of id_* control inputs, so an invalid slot never writes or accesses memory.
- Latency: one cycle ID to EX. One load-use hazard costs exactly one bubble. On the following cycle the load is in MEM, haz is 0, and MEM-to-EX forwarding supplies the value.
- A reset asserted mid-stall clears the bubble state immediately. The first post-reset cycle behaves as an empty pipeline.
- ex_halt propagates like any control bit and is squashed by flush or bubble.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with all id_* nonzero -> all ex_* and bubble_count read 0 immediately. load_use_stall=0.
- Load-use: LW R3 in EX, then ADD R5,R3,R4 in ID -> load_use_stall=1 for one cycle, ex_valid=0 next cycle, bubble_count=1. Next cycle the ADD is loaded with ex_rs=3.
- Store data exemption: LW R3 in EX, SW R3,0(R6) in ID -> no stall, SW loaded directly. With SW R7,0(R3) -> one bubble.
- R0 and non-load: LW R0 in EX followed by a reader of R0 -> no stall. ADD R3 (memread=0) followed by a reader of R3 -> no stall.
- Flush vs hazard: flush=1 with haz true -> load_use_stall=0, bubble inserted, bubble_count unchanged.
- Hold: ex_hold=1 for 3 cycles with flush=1 and new id_* values -> ex_* unchanged throughout. Force bubble_count to 16'hFFFF plus one more hazard -> it stays 16'hFFFF.

Source files
------------

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble/flush squashing
// and a saturating bubble counter for performance debug.
module id_ex_hazard_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   id_rd,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_memtoreg,
  input  logic               id_alusrc,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic               id_halt,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [DATA_W-1:0]  id_pc_next,
  input  logic               flush,
  input  logic               ex_hold,
  output logic               ex_valid,
  output logic [REG_W-1:0]   ex_rs,
  output logic [REG_W-1:0]   ex_rt,
  output logic [REG_W-1:0]   ex_rd,
  output logic               ex_regwrite,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_memtoreg,
  output logic               ex_alusrc,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_halt,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [DATA_W-1:0]  ex_pc_next,
  output logic               load_use_stall,
  output logic [CNT_W-1:0]   bubble_count
);

  typedef struct packed {
    logic               valid;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
    logic               halt;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  pc_next;
  } idex_t;

  idex_t ex_q, id_d;
  logic  haz, rs_hit, rt_hit;

  // Invalid slots carry no control so they can never write or touch memory.
  always_comb begin
    id_d          = '0;
    id_d.valid    = id_valid;
    id_d.rs       = id_rs;
    id_d.rt       = id_rt;
    id_d.rd       = id_rd;
    id_d.rs_data  = id_rs_data;
    id_d.rt_data  = id_rt_data;
    id_d.imm      = id_imm;
    id_d.pc_next  = id_pc_next;
    if (id_valid) begin
      id_d.regwrite = id_regwrite;
      id_d.memread  = id_memread;
      id_d.memwrite = id_memwrite;
      id_d.memtoreg = id_memtoreg;
      id_d.alusrc   = id_alusrc;
      id_d.aluop    = id_aluop;
      id_d.halt     = id_halt;
    end
  end

  // Store data (rt) is served by MEM-to-MEM forwarding, so it never stalls.
  assign rs_hit = id_uses_rs & (id_rs == ex_q.rd);
  assign rt_hit = id_uses_rt & (id_rt == ex_q.rd) & ~id_memwrite;
  assign haz    = ex_q.valid & ex_q.memread & (ex_q.rd != '0) & id_valid & (rs_hit | rt_hit);

  assign load_use_stall = haz & ~flush & ~ex_hold & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      bubble_count <= '0;
    end else if (!ex_hold) begin
      if (flush || haz) ex_q <= '0;
      else              ex_q <= id_d;
      if (haz && !flush && bubble_count != '1)
        bubble_count <= bubble_count + CNT_W'(1);
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_rd       = ex_q.rd;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_aluop    = ex_q.aluop;
  assign ex_halt     = ex_q.halt;
  assign ex_rs_data  = ex_q.rs_data;
  assign ex_rt_data  = ex_q.rt_data;
  assign ex_imm      = ex_q.imm;
  assign ex_pc_next  = ex_q.pc_next;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: directed vector table, reset/hold corner cases and
// randomized traffic against a slot-level reference model; a 4-bit counter copy covers saturation.
module tb_id_ex_hazard_stage;

  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic        id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, id_memwrite;
  logic        id_memtoreg, id_alusrc, id_halt, flush, ex_hold;
  logic [3:0]  id_rs, id_rt, id_rd, id_aluop;
  logic [15:0] id_rs_data, id_rt_data, id_imm, id_pc_next;

  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_halt;
  logic [3:0]  ex_rs, ex_rt, ex_rd, ex_aluop;
  logic [15:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_next, bubble_count;
  logic        load_use_stall;

  logic        s_valid, s_regwrite, s_memread, s_memwrite, s_memtoreg, s_alusrc, s_halt, s_stall;
  logic [3:0]  s_rs, s_rt, s_rd, s_aluop, s_count;
  logic [15:0] s_rs_data, s_rt_data, s_imm, s_pc_next;

  id_ex_hazard_stage u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_halt(id_halt), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc_next(id_pc_next), .flush(flush),
    .ex_hold(ex_hold), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .ex_halt(ex_halt),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc_next(ex_pc_next),
    .load_use_stall(load_use_stall), .bubble_count(bubble_count));

  id_ex_hazard_stage #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_halt(id_halt), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc_next(id_pc_next), .flush(flush),
    .ex_hold(ex_hold), .ex_valid(s_valid), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
    .ex_regwrite(s_regwrite), .ex_memread(s_memread), .ex_memwrite(s_memwrite),
    .ex_memtoreg(s_memtoreg), .ex_alusrc(s_alusrc), .ex_aluop(s_aluop), .ex_halt(s_halt),
    .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data), .ex_imm(s_imm), .ex_pc_next(s_pc_next),
    .load_use_stall(s_stall), .bubble_count(s_count));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what instruction sits in EX, plus the two bubble tallies.
  typedef struct {
    bit v, rw, mr, mw, mtr, as, halt;
    int rs, rt, rd, aluop, rsd, rtd, imm, pc;
  } slot_t;
  slot_t m;
  int mcnt, mcnt_s;

  function automatic bit model_haz();
    bit reads_it;
    reads_it = (id_uses_rs && int'(id_rs) == m.rd) ||
               (id_uses_rt && int'(id_rt) == m.rd && !id_memwrite);
    return m.v && m.mr && m.rd != 0 && id_valid && reads_it;
  endfunction

  task automatic model_reset();
    m = '{default: 0};
    mcnt = 0;
    mcnt_s = 0;
  endtask

  task automatic model_clock(input bit h);
    if (ex_hold) return;
    if (flush || h) begin
      m = '{default: 0};
      if (!flush) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt_s < 15) mcnt_s++;
      end
    end else begin
      m.v = id_valid; m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
      m.rsd = id_rs_data; m.rtd = id_rt_data; m.imm = id_imm; m.pc = id_pc_next;
      m.rw = id_valid && id_regwrite; m.mr = id_valid && id_memread;
      m.mw = id_valid && id_memwrite; m.mtr = id_valid && id_memtoreg;
      m.as = id_valid && id_alusrc; m.halt = id_valid && id_halt;
      m.aluop = id_valid ? int'(id_aluop) : 0;
    end
  endtask

  task automatic check_all();
    chk("ex_valid", ex_valid, m.v);        chk("ex_rs", ex_rs, m.rs);
    chk("ex_rt", ex_rt, m.rt);             chk("ex_rd", ex_rd, m.rd);
    chk("ex_regwrite", ex_regwrite, m.rw); chk("ex_memread", ex_memread, m.mr);
    chk("ex_memwrite", ex_memwrite, m.mw); chk("ex_memtoreg", ex_memtoreg, m.mtr);
    chk("ex_alusrc", ex_alusrc, m.as);     chk("ex_aluop", ex_aluop, m.aluop);
    chk("ex_halt", ex_halt, m.halt);       chk("ex_rs_data", ex_rs_data, m.rsd);
    chk("ex_rt_data", ex_rt_data, m.rtd);  chk("ex_imm", ex_imm, m.imm);
    chk("ex_pc_next", ex_pc_next, m.pc);   chk("bubble_count", bubble_count, mcnt);
    chk("bubble_count_sat", s_count, mcnt_s);
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic step();
    bit h;
    #1;
    h = model_haz();
    chk("load_use_stall", load_use_stall, h && !flush && !ex_hold);
    @(posedge clk);
    model_clock(h);
    #1;
    check_all();
  endtask

  task automatic set_in(input bit v, input int rs, input int rt, input int rd, input bit urs,
                        input bit urt, input bit rw, input bit mr, input bit mw,
                        input bit fl, input bit hd);
    id_valid = v; id_rs = 4'(rs); id_rt = 4'(rt); id_rd = 4'(rd);
    id_uses_rs = urs; id_uses_rt = urt; id_regwrite = rw; id_memread = mr; id_memwrite = mw;
    id_memtoreg = mr; id_alusrc = mr | mw; id_aluop = 4'($urandom); id_halt = 0;
    id_rs_data = 16'($urandom); id_rt_data = 16'($urandom);
    id_imm = 16'($urandom); id_pc_next = 16'($urandom);
    flush = fl; ex_hold = hd;
  endtask

  typedef struct {
    bit v; int rs, rt, rd; bit urs, urt, rw, mr, mw, fl, hd;
    bit e_stall, e_v; int e_rs; bit e_mr; int e_cnt;
  } vec_t;
  vec_t tv[21];

  function automatic vec_t mk(bit v, int rs, int rt, int rd, bit urs, bit urt, bit rw, bit mr,
                              bit mw, bit fl, bit hd, bit es, bit ev, int ers, bit emr, int ec);
    vec_t t;
    t = '{v, rs, rt, rd, urs, urt, rw, mr, mw, fl, hd, es, ev, ers, emr, ec};
    return t;
  endfunction

  initial begin
    //          v rs rt rd urs urt rw mr mw fl hd | stall v rs mr cnt
    tv[0]  = mk(1, 1, 0, 3, 1, 0, 1, 1, 0, 0, 0,  0, 1, 1, 1, 0); // LW R3
    tv[1]  = mk(1, 3, 4, 5, 1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 1); // ADD R5,R3,R4 -> bubble
    tv[2]  = mk(1, 3, 4, 5, 1, 1, 1, 0, 0, 0, 0,  0, 1, 3, 0, 1); // ADD loaded
    tv[3]  = mk(1, 1, 0, 3, 1, 0, 1, 1, 0, 0, 0,  0, 1, 1, 1, 1); // LW R3
    tv[4]  = mk(1, 6, 3, 0, 1, 1, 0, 0, 1, 0, 0,  0, 1, 6, 0, 1); // SW R3,0(R6): exempt
    tv[5]  = mk(1, 1, 0, 3, 1, 0, 1, 1, 0, 0, 0,  0, 1, 1, 1, 1); // LW R3
    tv[6]  = mk(1, 3, 7, 0, 1, 1, 0, 0, 1, 0, 0,  1, 0, 0, 0, 2); // SW R7,0(R3) -> bubble
    tv[7]  = mk(1, 3, 7, 0, 1, 1, 0, 0, 1, 0, 0,  0, 1, 3, 0, 2);
    tv[8]  = mk(1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0,  0, 1, 1, 1, 2); // LW R0
    tv[9]  = mk(1, 0, 0, 5, 1, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 2); // reads R0: no stall
    tv[10] = mk(1, 1, 2, 3, 1, 1, 1, 0, 0, 0, 0,  0, 1, 1, 0, 2); // ADD R3 (not a load)
    tv[11] = mk(1, 3, 4, 6, 1, 1, 1, 0, 0, 0, 0,  0, 1, 3, 0, 2); // reads R3: no stall
    tv[12] = mk(1, 1, 0, 3, 1, 0, 1, 1, 0, 0, 0,  0, 1, 1, 1, 2); // LW R3
    tv[13] = mk(1, 3, 4, 5, 1, 1, 1, 0, 0, 1, 0,  0, 0, 0, 0, 2); // flush beats hazard
    tv[14] = mk(1, 1, 0, 3, 1, 0, 1, 1, 0, 0, 0,  0, 1, 1, 1, 2); // LW R3
    tv[15] = mk(1, 3, 4, 5, 1, 1, 1, 0, 0, 1, 1,  0, 1, 1, 1, 2); // hold x3, flush ignored
    tv[16] = mk(1, 9, 8, 7, 1, 1, 1, 0, 0, 1, 1,  0, 1, 1, 1, 2);
    tv[17] = mk(1, 3, 2, 1, 1, 1, 1, 1, 0, 1, 1,  0, 1, 1, 1, 2);
    tv[18] = mk(1, 3, 4, 5, 1, 1, 1, 0, 0, 1, 0,  0, 0, 0, 0, 2); // flush after hold
    tv[19] = mk(0, 5, 0, 3, 1, 0, 1, 1, 1, 0, 0,  0, 0, 5, 0, 2); // invalid slot: no control
    tv[20] = mk(1, 3, 4, 5, 1, 1, 1, 0, 0, 0, 0,  0, 1, 3, 0, 2); // EX invalid: no stall

    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Build up state and a pending hazard, then reset mid-cycle.
    set_in(1, 1, 0, 3, 1, 0, 1, 1, 0, 0, 0); step();
    set_in(1, 3, 4, 5, 1, 1, 1, 0, 0, 0, 0); step();
    set_in(1, 1, 0, 3, 1, 0, 1, 1, 0, 0, 0); id_halt = 1; step();
    set_in(1, 3, 4, 5, 1, 1, 1, 0, 0, 0, 0); id_halt = 1;
    #1 chk("pre_reset_stall", load_use_stall, 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    check_all();
    chk("reset_stall", load_use_stall, 0);
    chk("reset_sat_valid", s_valid, 0);
    @(posedge clk);
    #1 check_all();
    rst_n = 1;
    step();

    foreach (tv[i]) begin
      set_in(tv[i].v, tv[i].rs, tv[i].rt, tv[i].rd, tv[i].urs, tv[i].urt, tv[i].rw,
             tv[i].mr, tv[i].mw, tv[i].fl, tv[i].hd);
      #1 chk($sformatf("vec%0d_stall", i), load_use_stall, tv[i].e_stall);
      step();
      chk($sformatf("vec%0d_valid", i), ex_valid, tv[i].e_v);
      chk($sformatf("vec%0d_rs", i), ex_rs, tv[i].e_rs);
      chk($sformatf("vec%0d_memread", i), ex_memread, tv[i].e_mr);
      chk($sformatf("vec%0d_count", i), bubble_count, tv[i].e_cnt);
    end

    // Randomized traffic on a small register set to make collisions common.
    for (int k = 0; k < 400; k++) begin
      set_in($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 25,
             $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15);
      id_halt = $urandom_range(0, 99) < 10;
      id_alusrc = $urandom_range(0, 1);
      step();
    end

    // Drive enough load-use pairs to pin the 4-bit counter at all-ones.
    for (int k = 0; k < 20; k++) begin
      set_in(1, 1, 0, 2, 1, 0, 1, 1, 0, 0, 0); step();
      set_in(1, 2, 1, 4, 1, 1, 1, 0, 0, 0, 0); step();
      step();
    end
    chk("sat_final", s_count, 15);
    chk("count_final", bubble_count, mcnt);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
